// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam logic [3:0] WEN_LOAD   = 4'b0000;
  localparam int         PERF_CNT_W = 32;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Saturating wait/conflict counters for the unified memory arbiter.
module arb_perf_counters
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  d_stall,
  input  logic                  conflict,
  output logic [PERF_CNT_W-1:0] perf_i_wait_cnt,
  output logic [PERF_CNT_W-1:0] perf_d_wait_cnt,
  output logic [PERF_CNT_W-1:0] perf_conflict_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_wait_cnt   <= '0;
      perf_d_wait_cnt   <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (i_stall)  perf_i_wait_cnt   <= sat_inc(perf_i_wait_cnt);
      if (d_stall)  perf_d_wait_cnt   <= sat_inc(perf_d_wait_cnt);
      if (conflict) perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and MEM stages.
// Define ARB_PERF_CNT_EN to add the perf_* wait/conflict counter outputs.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int D_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_stall,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_stall,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wen,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_i_wait_cnt,
  output logic [PERF_CNT_W-1:0] perf_d_wait_cnt,
  output logic [PERF_CNT_W-1:0] perf_conflict_cnt
`endif
);

  localparam logic [3:0] BURST_LIMIT = 4'(D_BURST_MAX);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic [3:0]  burst_q, burst_d;
  logic        m_req_d;
  logic [31:0] m_addr_d;
  logic [3:0]  m_wen_d;
  logic [31:0] m_wdata_d;
  logic        grant_d, grant_i, done;

  // D normally wins; once it has taken BURST_LIMIT grants past a waiting fetch, IF goes next.
  assign grant_d = d_req && !(i_req && (burst_q == BURST_LIMIT));
  assign grant_i = i_req && !grant_d;
  assign done    = (state_q == WAIT) && m_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      burst_q <= '0;
      m_req   <= 1'b0;
      m_addr  <= '0;
      m_wen   <= '0;
      m_wdata <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      m_req   <= m_req_d;
      m_addr  <= m_addr_d;
      m_wen   <= m_wen_d;
      m_wdata <= m_wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    m_req_d   = m_req;
    m_addr_d  = m_addr;
    m_wen_d   = m_wen;
    m_wdata_d = m_wdata;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d   = OWN_D;
          m_req_d   = 1'b1;
          m_addr_d  = d_addr;
          m_wen_d   = d_wen;
          m_wdata_d = d_wdata;
          state_d   = ISSUE;
          if (!i_req)                    burst_d = '0;
          else if (burst_q != BURST_LIMIT) burst_d = burst_q + 4'd1;
        end else if (grant_i) begin
          owner_d   = OWN_I;
          m_req_d   = 1'b1;
          m_addr_d  = i_addr;
          m_wen_d   = WEN_LOAD;
          m_wdata_d = '0;
          state_d   = ISSUE;
          burst_d   = '0;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion is forwarded in the same cycle the memory reports it.
    if (done) begin
      if (owner_q == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
    end
  end

  assign i_stall = i_req && !i_rvalid;
  assign d_stall = d_req && !d_rvalid;

`ifdef ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = (state_q == IDLE) && i_req && d_req;

  arb_perf_counters u_perf (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_stall           (i_stall),
    .d_stall           (d_stall),
    .conflict          (conflict),
    .perf_i_wait_cnt   (perf_i_wait_cnt),
    .perf_d_wait_cnt   (perf_d_wait_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter with a behavioural memory responder.
module tb_unified_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_rvalid, i_stall, d_rvalid, d_stall;
  logic        m_req, m_ready, m_rvalid;
  logic [3:0]  m_wen;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_wait_cnt, perf_d_wait_cnt, perf_conflict_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   acc_cnt = 0;
  int   ready_delay = 0;
  logic suppress = 1'b0;
  txn_t issue_q[$];
  txn_t done_q[$];

  unified_mem_arbiter #(.D_BURST_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_rvalid (i_rvalid),
    .i_stall  (i_stall),
    .d_req    (d_req),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_rvalid (d_rvalid),
    .d_stall  (d_stall),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_wen    (m_wen),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_wait_cnt   (perf_i_wait_cnt),
    .perf_d_wait_cnt   (perf_d_wait_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_wen   = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic expectTxn(input logic is_d, input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
    txn_t t;
    t.is_d = is_d; t.addr = a; t.wen = w; t.wdata = wd;
    issue_q.push_back(t);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("completion_count", done_cnt, target);
  endtask

  // Memory model: accepts after ready_delay m_req cycles, completes one cycle after acceptance.
  initial begin
    txn_t cur, e;
    logic acc = 1'b0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      if (!rst_n) begin
        acc = 1'b0;
        continue;
      end
      if (acc) begin
        checkOutput("m_req_in_wait", m_req, 1'b0);
        if (!suppress) begin
          acc = 1'b0;
          m_rvalid = 1'b1;
          m_rdata = mem_data(cur.addr);
          #1;
          if (done_q.size() == 0) begin
            checkOutput("done_q_nonempty", 0, 1);
          end else begin
            e = done_q.pop_front();
            checkOutput("i_rvalid", i_rvalid, !e.is_d);
            checkOutput("d_rvalid", d_rvalid, e.is_d);
            checkOutput(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, mem_data(e.addr));
            checkOutput("other_rdata_zero", e.is_d ? i_rdata : d_rdata, 32'h0);
            checkOutput("i_stall_at_done", i_stall, i_req && e.is_d);
            checkOutput("d_stall_at_done", d_stall, d_req && !e.is_d);
            done_cnt++;
            done_cyc = cyc;
          end
        end
      end else if (m_req) begin
        if (issue_q.size() == 0) begin
          checkOutput("unexpected_m_req", m_req, 1'b0);
        end else begin
          checkOutput("m_addr", m_addr, issue_q[0].addr);
          checkOutput("m_wen", m_wen, issue_q[0].wen);
          checkOutput("m_wdata", m_wdata, issue_q[0].wdata);
          if (ready_delay > 0) begin
            ready_delay--;
            checkOutput("no_rvalid_in_issue", {i_rvalid, d_rvalid}, 2'b00);
          end else begin
            m_ready = 1'b1;
            acc = 1'b1;
            cur = issue_q.pop_front();
            done_q.push_back(cur);
            acc_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int t0, base;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] pi0, pd0, pc0;
`endif
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 4'h0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_m_req", m_req, 1'b0);
    checkOutput("rst_m_addr", m_addr, 32'h0);
    checkOutput("rst_m_wen", m_wen, 4'h0);
    checkOutput("rst_m_wdata", m_wdata, 32'h0);
    checkOutput("rst_rvalids", {i_rvalid, d_rvalid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single fetch");
    expectTxn(1'b0, 32'h100, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'h100, 1'b0, 4'h0, '0, '0);
    t0 = cyc;
    #1;
    checkOutput("fetch_i_stall", i_stall, 1'b1);
    waitDone(1, 20);
    checkOutput("fetch_latency", done_cyc - t0, 2);
    i_req = 1'b0;
    @(negedge clk);

    $display("[TB] collision");
`ifdef ARB_PERF_CNT_EN
    pi0 = perf_i_wait_cnt; pd0 = perf_d_wait_cnt; pc0 = perf_conflict_cnt;
`endif
    expectTxn(1'b1, 32'h2000, 4'hF, 32'hDEAD_BEEF);
    expectTxn(1'b0, 32'h104, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'h104, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF);
    waitDone(2, 20);
    d_req = 1'b0;
    #1;
    checkOutput("collision_i_stall", i_stall, 1'b1);
    waitDone(3, 20);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf_conflict", perf_conflict_cnt - pc0, 32'd1);
    checkOutput("perf_i_wait", perf_i_wait_cnt - pi0, 32'd5);
    checkOutput("perf_d_wait", perf_d_wait_cnt - pd0, 32'd2);
`endif

    $display("[TB] backpressure");
    base = acc_cnt;
    ready_delay = 5;
    expectTxn(1'b1, 32'h3004, 4'h5, 32'hCAFE_F00D);
    applyStimulus(1'b0, '0, 1'b1, 4'h5, 32'h3004, 32'hCAFE_F00D);
    waitDone(4, 40);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("single_accept", acc_cnt, base + 1);

    $display("[TB] starvation guard");
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) expectTxn(1'b0, 32'h200, 4'h0, 32'h0);
      else                  expectTxn(1'b1, 32'h4000, 4'h3, 32'h55AA_55AA);
    end
    applyStimulus(1'b1, 32'h200, 1'b1, 4'h3, 32'h4000, 32'h55AA_55AA);
    waitDone(14, 200);
    applyStimulus(1'b0, '0, 1'b0, 4'h0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("burst_queue_drained", issue_q.size(), 0);
    checkOutput("idle_m_req", m_req, 1'b0);

    $display("[TB] reset in wait");
    suppress = 1'b1;
    base = acc_cnt;
    expectTxn(1'b1, 32'h5000, 4'h0, 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 4'h0, 32'h5000, 32'h0);
    for (int n = 0; n < 20 && acc_cnt == base; n++) @(negedge clk);
    checkOutput("reset_txn_accepted", acc_cnt, base + 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_req", m_req, 1'b0);
    checkOutput("mid_rst_rvalids", {i_rvalid, d_rvalid}, 2'b00);
    checkOutput("mid_rst_m_addr", m_addr, 32'h0);
    d_req = 1'b0;
    done_q.delete();
    suppress = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expectTxn(1'b0, 32'h600, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'h600, 1'b0, 4'h0, '0, '0);
    waitDone(15, 20);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
